// File: rtl/conv_frame_sched_pkg.sv
// Shared types and frame-size helpers for the conv batch scheduler.
// The conv engine imports the same helpers so both sides agree on frame sizes.
package conv_frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RELEASE,
    ST_NEXT,
    ST_FINISH
  } sched_state_e;

  function automatic logic [31:0] frame_in_bytes(input int unsigned w, input int unsigned h);
    return 32'(w * h * 4);
  endfunction

  // 3x3 kernel without padding trims one pixel from every border
  function automatic logic [31:0] frame_out_bytes(input int unsigned w, input int unsigned h);
    return 32'((w - 2) * (h - 2) * 4);
  endfunction

endpackage

// File: rtl/conv_frame_sched_if.sv
// Host command channel of the conv batch scheduler: valid/ready plus frame count and BRAM bases.
interface conv_frame_sched_if #(
  parameter int unsigned MAX_FRAMES = 16
);
  localparam int unsigned FW = $clog2(MAX_FRAMES + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [FW-1:0] cmd_frames;
  logic [31:0]   cmd_in_base;
  logic [31:0]   cmd_out_base;

  modport master (
    output cmd_valid, cmd_frames, cmd_in_base, cmd_out_base,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_frames, cmd_in_base, cmd_out_base,
    output cmd_ready
  );
endinterface

// File: rtl/conv_frame_sched.sv
// Batch scheduler: runs the Sobel conv engine once per frame over consecutive BRAM frame slots,
// offsetting engine addresses by the current frame base and reporting busy/irq/progress to the host.
module conv_frame_sched
  import conv_frame_sched_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH  = 32,
  parameter  int unsigned IMG_HEIGHT = 32,
  parameter  int unsigned MAX_FRAMES = 16,
  localparam int unsigned FW         = $clog2(MAX_FRAMES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_frame_sched_if.slave   cmd,
  output logic                busy,
  output logic                irq,
  output logic [FW-1:0]       frames_done,
  output logic [31:0]         cycle_count,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [31:0]         conv_bram0_addr,
  input  logic                conv_bram0_en,
  input  logic [31:0]         conv_bram1_addr,
  input  logic [31:0]         conv_bram1_din,
  input  logic [3:0]          conv_bram1_we,
  output logic [31:0]         bram0_addr,
  output logic                bram0_en,
  output logic [31:0]         bram1_addr,
  output logic [31:0]         bram1_din,
  output logic [3:0]          bram1_we
);

  localparam logic [31:0]   FRAME_IN_BYTES  = frame_in_bytes(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [31:0]   FRAME_OUT_BYTES = frame_out_bytes(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [FW-1:0] MAX_FRAMES_FW   = FW'(MAX_FRAMES);

  sched_state_e  state_q, state_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          irq_q, irq_d;
  logic [FW-1:0] frames_done_q, frames_done_d;
  logic [FW-1:0] remaining_q, remaining_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   in_base_q, in_base_d;
  logic [31:0]   out_base_q, out_base_d;
  logic [FW-1:0] req_frames;

  always_comb begin
    req_frames    = (cmd.cmd_frames > MAX_FRAMES_FW) ? MAX_FRAMES_FW : cmd.cmd_frames;
    state_d       = state_q;
    start_d       = start_q;
    busy_d        = busy_q;
    irq_d         = 1'b0;
    frames_done_d = frames_done_q;
    remaining_d   = remaining_q;
    in_base_d     = in_base_q;
    out_base_d    = out_base_q;
    cycle_d       = (busy_q && (cycle_q != '1)) ? cycle_q + 32'd1 : cycle_q;

    // start/irq are set on the transition into their state so they are registered, not decoded
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          in_base_d     = cmd.cmd_in_base & ~32'h3;
          out_base_d    = cmd.cmd_out_base & ~32'h3;
          remaining_d   = req_frames;
          frames_done_d = '0;
          cycle_d       = '0;
          busy_d        = 1'b1;
          if (req_frames == '0) begin
            state_d = ST_FINISH;
            irq_d   = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
            start_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (conv_done) begin
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!conv_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        frames_done_d = frames_done_q + FW'(1);
        remaining_d   = remaining_q - FW'(1);
        in_base_d     = in_base_q + FRAME_IN_BYTES;
        out_base_d    = out_base_q + FRAME_OUT_BYTES;
        if (remaining_q == FW'(1)) begin
          state_d = ST_FINISH;
          irq_d   = 1'b1;
        end else begin
          state_d = ST_LAUNCH;
          start_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      frames_done_q <= '0;
      remaining_q   <= '0;
      cycle_q       <= '0;
      in_base_q     <= '0;
      out_base_q    <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      frames_done_q <= frames_done_d;
      remaining_q   <= remaining_d;
      cycle_q       <= cycle_d;
      in_base_q     <= in_base_d;
      out_base_q    <= out_base_d;
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q == ST_IDLE);
    busy          = busy_q;
    irq           = irq_q;
    frames_done   = frames_done_q;
    cycle_count   = cycle_q;
    conv_start    = start_q;
    bram0_addr    = conv_bram0_addr + in_base_q;
    bram0_en      = conv_bram0_en;
    bram1_addr    = conv_bram1_addr + out_base_q;
    bram1_din     = conv_bram1_din;
    bram1_we      = (state_q == ST_RUN) ? conv_bram1_we : '0;
  end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Directed bench for conv_frame_sched with a behavioural conv engine (done N cycles after start).
module tb_conv_frame_sched;

  localparam int unsigned MAXF = 16;
  localparam int unsigned FW   = $clog2(MAXF + 1);
  localparam int unsigned NDLY = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy, irq, conv_start;
  logic          conv_done;
  logic [FW-1:0] frames_done;
  logic [31:0]   cycle_count;
  logic [31:0]   conv_bram0_addr = '0, conv_bram1_addr = '0, conv_bram1_din = '0;
  logic          conv_bram0_en = 1'b0;
  logic [3:0]    conv_bram1_we = '0;
  logic [31:0]   bram0_addr, bram1_addr, bram1_din;
  logic          bram0_en;
  logic [3:0]    bram1_we;

  int n_checks = 0;
  int n_pass   = 0;
  int start_rises = 0;
  int irq_cycles  = 0;
  logic start_prev = 1'b0;
  int mcnt;

  conv_frame_sched_if #(.MAX_FRAMES(MAXF)) cmd_if ();

  conv_frame_sched #(.IMG_WIDTH(32), .IMG_HEIGHT(32), .MAX_FRAMES(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .busy(busy), .irq(irq), .frames_done(frames_done), .cycle_count(cycle_count),
    .conv_start(conv_start), .conv_done(conv_done),
    .conv_bram0_addr(conv_bram0_addr), .conv_bram0_en(conv_bram0_en),
    .conv_bram1_addr(conv_bram1_addr), .conv_bram1_din(conv_bram1_din),
    .conv_bram1_we(conv_bram1_we),
    .bram0_addr(bram0_addr), .bram0_en(bram0_en), .bram1_addr(bram1_addr),
    .bram1_din(bram1_din), .bram1_we(bram1_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_done <= 1'b0;
      mcnt      <= 0;
    end else if (!conv_start) begin
      conv_done <= 1'b0;
      mcnt      <= 0;
    end else if (mcnt == NDLY - 1) begin
      conv_done <= 1'b1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (conv_start && !start_prev) start_rises++;
    if (irq) irq_cycles++;
    start_prev = conv_start;
  end

  task automatic send_cmd(input logic [FW-1:0] frames, input logic [31:0] inb, input logic [31:0] outb);
    @(negedge clk);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_frames   = frames;
    cmd_if.cmd_in_base  = inb;
    cmd_if.cmd_out_base = outb;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input logic level, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (conv_start === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_irq(input int limit, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cyc++;
      if (irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    conv_bram1_we   = 4'hF;
    conv_bram0_addr = 32'h10;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_if.cmd_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else n_pass++;
    n_checks++; if (conv_start !== 1'b0) $display("FAIL reset_start got=%b exp=0", conv_start); else n_pass++;
    n_checks++; if (frames_done !== '0) $display("FAIL reset_frames got=%0d exp=0", frames_done); else n_pass++;
    n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_cycles got=%0d exp=0", cycle_count); else n_pass++;
    n_checks++; if (bram1_we !== 4'h0) $display("FAIL reset_we got=%h exp=0", bram1_we); else n_pass++;
    n_checks++; if (bram0_addr !== 32'h10) $display("FAIL reset_addr0 got=%h exp=10", bram0_addr); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", cmd_if.cmd_ready); else n_pass++;
  endtask

  task automatic test_one_frame();
    int s0, i0, el, cyc;
    bit ok;
    s0 = start_rises; i0 = irq_cycles;
    conv_bram0_addr = 32'h10; conv_bram1_addr = 32'h24; conv_bram1_we = 4'hF;
    conv_bram1_din = 32'hDEAD_BEEF; conv_bram0_en = 1'b1;
    send_cmd(FW'(1), 32'h0, 32'h0);
    @(negedge clk); el = 1;
    n_checks++; if (conv_start !== 1'b1) $display("FAIL one_start_latency got=%b exp=1", conv_start); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL one_busy got=%b exp=1", busy); else n_pass++;
    n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL one_ready got=%b exp=0", cmd_if.cmd_ready); else n_pass++;
    n_checks++; if (bram1_we !== 4'h0) $display("FAIL one_we_launch got=%h exp=0", bram1_we); else n_pass++;
    @(negedge clk); el++;
    n_checks++; if (bram0_addr !== 32'h10) $display("FAIL one_addr0 got=%h exp=10", bram0_addr); else n_pass++;
    n_checks++; if (bram1_addr !== 32'h24) $display("FAIL one_addr1 got=%h exp=24", bram1_addr); else n_pass++;
    n_checks++; if (bram1_we !== 4'hF) $display("FAIL one_we_run got=%h exp=F", bram1_we); else n_pass++;
    n_checks++; if ({bram0_en, bram1_din} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL one_passthru got=%b/%h exp=1/deadbeef", bram0_en, bram1_din); else n_pass++;
    wait_irq(200, cyc, ok); el += cyc;
    n_checks++; if (!ok) $display("FAIL one_irq_timeout got=none exp=irq"); else n_pass++;
    n_checks++; if (frames_done !== FW'(1)) $display("FAIL one_frames got=%0d exp=1", frames_done); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL one_busy_after got=%b exp=0", busy); else n_pass++;
    n_checks++; if (irq_cycles - i0 !== 1) $display("FAIL one_irq_count got=%0d exp=1", irq_cycles - i0); else n_pass++;
    n_checks++; if (start_rises - s0 !== 1) $display("FAIL one_starts got=%0d exp=1", start_rises - s0); else n_pass++;
    n_checks++; if (cycle_count !== 32'(el)) $display("FAIL one_cycles got=%0d exp=%0d", cycle_count, el); else n_pass++;
  endtask

  task automatic test_three_frames();
    int s0, i0, cyc;
    bit ok;
    logic [31:0] exp0, exp1;
    s0 = start_rises; i0 = irq_cycles;
    conv_bram0_addr = 32'h40; conv_bram1_addr = 32'h8;
    send_cmd(FW'(3), 32'h1000, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      wait_start(1'b1, 50, ok);
      n_checks++; if (!ok) $display("FAIL three_start_timeout frame=%0d got=none exp=start", k); else n_pass++;
      @(negedge clk);
      exp0 = 32'h40 + 32'h1000 + 32'(k) * 32'h1000;
      exp1 = 32'h8 + 32'h2000 + 32'(k) * 32'd3600;
      n_checks++; if (bram0_addr !== exp0) $display("FAIL three_addr0 frame=%0d got=%h exp=%h", k, bram0_addr, exp0); else n_pass++;
      n_checks++; if (bram1_addr !== exp1) $display("FAIL three_addr1 frame=%0d got=%h exp=%h", k, bram1_addr, exp1); else n_pass++;
      wait_start(1'b0, 50, ok);
      n_checks++; if (!ok) $display("FAIL three_stop_timeout frame=%0d got=none exp=stop", k); else n_pass++;
    end
    wait_irq(100, cyc, ok);
    n_checks++; if (!ok) $display("FAIL three_irq_timeout got=none exp=irq"); else n_pass++;
    n_checks++; if (frames_done !== FW'(3)) $display("FAIL three_frames got=%0d exp=3", frames_done); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (start_rises - s0 !== 3) $display("FAIL three_starts got=%0d exp=3", start_rises - s0); else n_pass++;
    n_checks++; if (irq_cycles - i0 !== 1) $display("FAIL three_irqs got=%0d exp=1", irq_cycles - i0); else n_pass++;
  endtask

  task automatic test_zero_frames();
    int s0;
    s0 = start_rises;
    send_cmd(FW'(0), 32'h5000, 32'h6000);
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) $display("FAIL zero_irq_latency got=%b exp=1", irq); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL zero_busy_finish got=%b exp=1", busy); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (cycle_count !== 32'd1) $display("FAIL zero_cycles got=%0d exp=1", cycle_count); else n_pass++;
    n_checks++; if (frames_done !== '0) $display("FAIL zero_frames got=%0d exp=0", frames_done); else n_pass++;
    n_checks++; if (start_rises - s0 !== 0) $display("FAIL zero_starts got=%0d exp=0", start_rises - s0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy_after got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_clamp();
    int s0, k, cyc;
    bit ok;
    logic [31:0] exp0;
    s0 = start_rises;
    conv_bram0_addr = 32'h20;
    send_cmd(FW'(31), 32'h0, 32'h0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_frames = FW'(2);
      cmd_if.cmd_in_base = 32'hAAAA_0000; cmd_if.cmd_out_base = 32'h5555_0000;
      #1;
      n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL clamp_ready_busy got=%b exp=0", cmd_if.cmd_ready); else n_pass++;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    wait_start(1'b0, 50, ok);
    wait_start(1'b1, 50, ok);
    n_checks++; if (!ok) $display("FAIL clamp_start_timeout got=none exp=start"); else n_pass++;
    @(negedge clk);
    k = start_rises - s0 - 1;
    exp0 = 32'h20 + 32'(k) * 32'h1000;
    n_checks++; if (bram0_addr !== exp0) $display("FAIL clamp_base_kept got=%h exp=%h", bram0_addr, exp0); else n_pass++;
    wait_irq(3000, cyc, ok);
    n_checks++; if (!ok) $display("FAIL clamp_irq_timeout got=none exp=irq"); else n_pass++;
    n_checks++; if (frames_done !== FW'(16)) $display("FAIL clamp_frames got=%0d exp=16", frames_done); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (start_rises - s0 !== 16) $display("FAIL clamp_starts got=%0d exp=16", start_rises - s0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    conv_bram0_addr = 32'h10; conv_bram1_addr = 32'h30;
    send_cmd(FW'(3), 32'h100, 32'h200);
    wait_start(1'b1, 50, ok);
    wait_start(1'b0, 50, ok);
    wait_start(1'b1, 50, ok);
    n_checks++; if (!ok) $display("FAIL mid_start2_timeout got=none exp=start"); else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (conv_start !== 1'b0) $display("FAIL mid_start got=%b exp=0", conv_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (frames_done !== '0) $display("FAIL mid_frames got=%0d exp=0", frames_done); else n_pass++;
    n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", cmd_if.cmd_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(FW'(1), 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bram0_addr !== 32'h10) $display("FAIL mid_new_addr0 got=%h exp=10", bram0_addr); else n_pass++;
    n_checks++; if (bram1_addr !== 32'h30) $display("FAIL mid_new_addr1 got=%h exp=30", bram1_addr); else n_pass++;
    wait_irq(200, cyc, ok);
    n_checks++; if (!ok) $display("FAIL mid_irq_timeout got=none exp=irq"); else n_pass++;
    n_checks++; if (frames_done !== FW'(1)) $display("FAIL mid_new_frames got=%0d exp=1", frames_done); else n_pass++;
  endtask

  initial begin
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_frames   = '0;
    cmd_if.cmd_in_base  = '0;
    cmd_if.cmd_out_base = '0;
    test_reset();
    test_one_frame();
    test_three_frames();
    test_zero_frames();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
